// File: rtl/rast_tri_arb_pkg.sv
// Shared types and constants for the triangle arbiter: FSM states, power-on
// configuration and the subSample one-hot decode.
package rast_tri_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_QUIET = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  // Default screen is 512.0 in fixed point; the top shifts by its RADIX.
  localparam int unsigned DEF_SCREEN_WHOLE = 32'd512;
  localparam logic [3:0]  DEF_SUBSAMPLE    = 4'b0100;
  localparam logic [1:0]  DEF_SS_W_LG2     = 2'd1;

  typedef struct packed {
    logic       legal;
    logic [1:0] lg2;
  } ss_dec_t;

  function automatic ss_dec_t ss_decode(input logic [3:0] ss);
    ss_dec_t r;
    case (ss)
      4'b1000: r = '{legal: 1'b1, lg2: 2'd0};
      4'b0100: r = '{legal: 1'b1, lg2: 2'd1};
      4'b0010: r = '{legal: 1'b1, lg2: 2'd2};
      4'b0001: r = '{legal: 1'b1, lg2: 2'd3};
      default: r = '{legal: 1'b0, lg2: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rast_rr_arb2.sv
// Two-way round-robin arbiter: the grant is combinational from the valids and
// the pointer; the pointer follows the winner only when a transfer happens.
module rast_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vld,
  input  logic       adv,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Grant: a lone requester wins; on a tie the one not holding the pointer wins.
  always_comb begin
    grant = 2'b00;
    case (vld)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer next state: move to the granted index on a transfer only.
  always_comb begin
    if (adv && (grant != 2'b00)) begin
      ptr_d = grant[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rast_tri_arb.sv
// Arbitrates two triangle sources into a single registered rasterizer stage and
// applies screen/subSample changes only after the pipe has drained and gone quiet.
module rast_tri_arb
  import rast_tri_arb_pkg::*;
#(
  parameter int SIGFIG    = 24,
  parameter int RADIX     = 10,
  parameter int VERTS     = 3,
  parameter int AXIS      = 3,
  parameter int COLORS    = 3,
  parameter int DRAIN_CYC = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_RnnnnL,
  input  logic [1:0]                                    req_vld_R0H,
  input  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri_R0S,
  input  logic [1:0][COLORS-1:0][SIGFIG-1:0]            req_color_R0U,
  output logic [1:0]                                    req_rdy_R0H,
  input  logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]                 color_R10U,
  output logic                                          validTri_R10H,
  output logic                                          src_R10U,
  input  logic                                          cfg_vld_RnnnnH,
  input  logic signed [1:0][SIGFIG-1:0]                 cfg_screen_RnnnnS,
  input  logic [3:0]                                    cfg_subSample_RnnnnU,
  output logic                                          cfg_rdy_RnnnnH,
  output logic signed [1:0][SIGFIG-1:0]                 screen_RnnnnS,
  output logic [3:0]                                    subSample_RnnnnU,
  output logic [1:0]                                    ss_w_lg2_RnnnnS,
  output logic                                          cfg_err_RnnnnH,
  output logic                                          busy_RnnnnH
);

  localparam logic [SIGFIG-1:0] DEF_SCR  = SIGFIG'(DEF_SCREEN_WHOLE) << RADIX;
  localparam logic [4:0]        QUIET_LAST = 5'(DRAIN_CYC - 1);

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic valid_q, valid_d, src_q, src_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0] color_q, color_d;
  logic [1:0][SIGFIG-1:0] screen_q, screen_d;
  logic [3:0] ss_q, ss_d;
  logic [1:0] lg2_q, lg2_d;
  logic err_q, err_d, cfg_rdy_q, cfg_rdy_d, busy_q, busy_d;

  logic [1:0] grant_s;
  logic load_ok_s, load_s;
  ss_dec_t dec_s;

  assign load_ok_s = (state_q == ST_RUN) && (!valid_q || halt_RnnnnL);
  assign load_s    = load_ok_s && (req_vld_R0H != 2'b00);
  assign dec_s     = ss_decode(cfg_subSample_RnnnnU);
  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign req_rdy_R0H = grant_s & {2{load_ok_s & rst_RnnnnL}};

  rast_rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_RnnnnL),
    .vld   (req_vld_R0H),
    .adv   (load_ok_s),
    .grant (grant_s)
  );

  // Output stage next state: load wins over consume, consume only drops the valid.
  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    tri_d   = tri_q;
    color_d = color_q;
    if (load_s) begin
      valid_d = 1'b1;
      src_d   = grant_s[1];
      tri_d   = req_tri_R0S[grant_s[1]];
      color_d = req_color_R0U[grant_s[1]];
    end else if (valid_q && halt_RnnnnL) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Config FSM next state, quiet counter and configuration update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = 5'd0;
    screen_d = screen_q;
    ss_d     = ss_q;
    lg2_d    = lg2_q;
    err_d    = err_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_vld_RnnnnH) state_d = ST_DRAIN;
        else                state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!valid_q) state_d = ST_QUIET;
        else          state_d = ST_DRAIN;
      end
      ST_QUIET: begin
        if (cnt_q == QUIET_LAST) state_d = ST_APPLY;
        else if (halt_RnnnnL)    cnt_d   = cnt_q + 5'd1;
        else                     cnt_d   = 5'd0;
      end
      ST_APPLY: begin
        state_d = ST_RUN;
        if (dec_s.legal) begin
          screen_d = cfg_screen_RnnnnS;
          ss_d     = cfg_subSample_RnnnnU;
          lg2_d    = dec_s.lg2;
          err_d    = 1'b0;
        end else begin
          err_d    = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    cfg_rdy_d = (state_d == ST_APPLY);
    busy_d    = (state_d != ST_RUN) || valid_d;
  end

  // All state: FSM, output stage and configuration registers.
  always_ff @(posedge clk or negedge rst_RnnnnL) begin
    if (!rst_RnnnnL) begin
      state_q   <= ST_RUN;
      cnt_q     <= 5'd0;
      valid_q   <= 1'b0;
      src_q     <= 1'b0;
      tri_q     <= '0;
      color_q   <= '0;
      screen_q  <= {DEF_SCR, DEF_SCR};
      ss_q      <= DEF_SUBSAMPLE;
      lg2_q     <= DEF_SS_W_LG2;
      err_q     <= 1'b0;
      cfg_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      tri_q     <= tri_d;
      color_q   <= color_d;
      screen_q  <= screen_d;
      ss_q      <= ss_d;
      lg2_q     <= lg2_d;
      err_q     <= err_d;
      cfg_rdy_q <= cfg_rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign validTri_R10H    = valid_q;
  assign src_R10U         = src_q;
  assign tri_R10S         = tri_q;
  assign color_R10U       = color_q;
  assign screen_RnnnnS    = screen_q;
  assign subSample_RnnnnU = ss_q;
  assign ss_w_lg2_RnnnnS  = lg2_q;
  assign cfg_err_RnnnnH   = err_q;
  assign cfg_rdy_RnnnnH   = cfg_rdy_q;
  assign busy_RnnnnH      = busy_q;

endmodule

// File: tb/tb_rast_tri_arb.sv
// Directed self-checking bench for rast_tri_arb: reset, single transfer, round
// robin, halt stall, config drain/quiet/apply, illegal config and async reset.
module tb_rast_tri_arb;

  localparam int SF = 24;
  localparam logic [SF-1:0] DEF_SCR = 24'h080000;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_vld;
  logic signed [1:0][2:0][2:0][SF-1:0] req_tri;
  logic [1:0][2:0][SF-1:0] req_color;
  logic [1:0] req_rdy;
  logic halt;
  logic signed [2:0][2:0][SF-1:0] tri_o;
  logic [2:0][SF-1:0] color_o;
  logic valid_o, src_o;
  logic cfg_vld;
  logic signed [1:0][SF-1:0] cfg_screen;
  logic [3:0] cfg_ss;
  logic cfg_rdy;
  logic signed [1:0][SF-1:0] screen_o;
  logic [3:0] ss_o;
  logic [1:0] lg2_o;
  logic err_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rast_tri_arb dut (
    .clk(clk), .rst_RnnnnL(rst_n),
    .req_vld_R0H(req_vld), .req_tri_R0S(req_tri), .req_color_R0U(req_color),
    .req_rdy_R0H(req_rdy), .halt_RnnnnL(halt),
    .tri_R10S(tri_o), .color_R10U(color_o), .validTri_R10H(valid_o), .src_R10U(src_o),
    .cfg_vld_RnnnnH(cfg_vld), .cfg_screen_RnnnnS(cfg_screen),
    .cfg_subSample_RnnnnU(cfg_ss), .cfg_rdy_RnnnnH(cfg_rdy),
    .screen_RnnnnS(screen_o), .subSample_RnnnnU(ss_o), .ss_w_lg2_RnnnnS(lg2_o),
    .cfg_err_RnnnnH(err_o), .busy_RnnnnH(busy_o)
  );

  function automatic logic [2:0][2:0][SF-1:0] tri_pat(input int id, input int n);
    logic [2:0][2:0][SF-1:0] r;
    logic [SF-1:0] x;
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) begin
        x = SF'(id * 32'h100000 + n * 32'h100 + v * 32'h10 + a + 1);
        r[v][a] = (((v + a) % 2) == 1) ? -x : x;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0][SF-1:0] col_pat(input int id, input int n);
    logic [2:0][SF-1:0] r;
    for (int c = 0; c < 3; c++) r[c] = SF'(id * 32'h200000 + n * 32'h40 + c + 5);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cfg(input logic [SF-1:0] scr, input logic [3:0] ss, output bit ok);
    cfg_vld = 1'b1; cfg_screen = {scr, scr}; cfg_ss = ss; halt = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (cfg_rdy) begin ok = 1'b1; break; end
    end
    step();
    cfg_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 2'b11; halt = 1'b1; cfg_vld = 1'b0;
    cfg_screen = '0; cfg_ss = 4'b0000;
    req_tri[0] = tri_pat(0, 1); req_tri[1] = tri_pat(1, 1);
    req_color[0] = col_pat(0, 1); req_color[1] = col_pat(1, 1);
    step(); step();
    n_cmp++; if (req_rdy !== 2'b00) begin n_bad++; $display("FAIL rst_req_rdy got %b want 00", req_rdy); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid_o); end
    n_cmp++; if (tri_o !== '0 || color_o !== '0 || src_o !== 1'b0) begin n_bad++; $display("FAIL rst_data tri %h color %h src %b want zeros", tri_o, color_o, src_o); end
    n_cmp++; if (screen_o !== {DEF_SCR, DEF_SCR}) begin n_bad++; $display("FAIL rst_screen got %h want %h", screen_o, {DEF_SCR, DEF_SCR}); end
    n_cmp++; if (ss_o !== 4'b0100 || lg2_o !== 2'd1) begin n_bad++; $display("FAIL rst_ss got %b/%0d want 0100/1", ss_o, lg2_o); end
    n_cmp++; if (err_o !== 1'b0 || cfg_rdy !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_flags err %b rdy %b busy %b want 0 0 0", err_o, cfg_rdy, busy_o); end
    req_vld = 2'b00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_vld = 2'b01; req_tri[0] = tri_pat(0, 10); req_color[0] = col_pat(0, 10);
    #1;
    n_cmp++; if (req_rdy !== 2'b01) begin n_bad++; $display("FAIL single_rdy got %b want 01", req_rdy); end
    step();
    req_vld = 2'b00;
    n_cmp++; if (valid_o !== 1'b1 || src_o !== 1'b0) begin n_bad++; $display("FAIL single_valid got v%b s%b want v1 s0", valid_o, src_o); end
    n_cmp++; if (tri_o !== tri_pat(0, 10) || color_o !== col_pat(0, 10)) begin n_bad++; $display("FAIL single_data got %h want %h", tri_o, tri_pat(0, 10)); end
    step();
    n_cmp++; if (valid_o !== 1'b0 || tri_o !== tri_pat(0, 10)) begin n_bad++; $display("FAIL consume_hold got v%b %h want v0 %h", valid_o, tri_o, tri_pat(0, 10)); end
  endtask

  task automatic test_round_robin();
    int cnt0, cnt1;
    logic [1:0] rdy_snap, exp_rdy;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    cnt0 = 0; cnt1 = 0;
    req_tri[0] = tri_pat(0, 0); req_color[0] = col_pat(0, 0);
    req_tri[1] = tri_pat(1, 0); req_color[1] = col_pat(1, 0);
    req_vld = 2'b11; halt = 1'b1;
    #1;
    for (int k = 0; k < 100; k++) begin
      rdy_snap = req_rdy;
      exp_rdy = ((k % 2) == 1) ? 2'b10 : 2'b01;
      n_cmp++; if (rdy_snap !== exp_rdy) begin n_bad++; $display("FAIL rr_rdy[%0d] got %b want %b", k, rdy_snap, exp_rdy); end
      step();
      n_cmp++;
      if (valid_o !== 1'b1 || src_o !== 1'((k % 2)) || tri_o !== tri_pat(k % 2, k / 2) || color_o !== col_pat(k % 2, k / 2)) begin
        n_bad++; $display("FAIL rr_out[%0d] got v%b s%b %h want s%0d %h", k, valid_o, src_o, tri_o, k % 2, tri_pat(k % 2, k / 2));
      end
      if (rdy_snap[0]) begin cnt0++; req_tri[0] = tri_pat(0, cnt0); req_color[0] = col_pat(0, cnt0); end
      if (rdy_snap[1]) begin cnt1++; req_tri[1] = tri_pat(1, cnt1); req_color[1] = col_pat(1, cnt1); end
      #1;
    end
    req_vld = 2'b00;
    step();
  endtask

  task automatic test_halt();
    req_vld = 2'b01; req_tri[0] = tri_pat(0, 200); req_color[0] = col_pat(0, 200);
    step();
    halt = 1'b0; req_tri[0] = tri_pat(0, 201); req_color[0] = col_pat(0, 201);
    for (int c = 0; c < 7; c++) begin
      #1;
      n_cmp++; if (req_rdy !== 2'b00) begin n_bad++; $display("FAIL halt_rdy[%0d] got %b want 00", c, req_rdy); end
      step();
      n_cmp++; if (valid_o !== 1'b1 || tri_o !== tri_pat(0, 200)) begin n_bad++; $display("FAIL halt_hold[%0d] got v%b %h want %h", c, valid_o, tri_o, tri_pat(0, 200)); end
    end
    halt = 1'b1;
    #1;
    n_cmp++; if (req_rdy !== 2'b01) begin n_bad++; $display("FAIL halt_release_rdy got %b want 01", req_rdy); end
    step();
    req_vld = 2'b00;
    n_cmp++; if (valid_o !== 1'b1 || tri_o !== tri_pat(0, 201)) begin n_bad++; $display("FAIL halt_next got v%b %h want %h", valid_o, tri_o, tri_pat(0, 201)); end
    step();
  endtask

  task automatic test_cfg_apply();
    int seen;
    req_vld = 2'b01; req_tri[0] = tri_pat(0, 300); req_color[0] = col_pat(0, 300);
    step();
    req_vld = 2'b00; halt = 1'b0;
    cfg_vld = 1'b1; cfg_screen = {24'h040000, 24'h040000}; cfg_ss = 4'b0010;
    step();
    n_cmp++; if (valid_o !== 1'b1 || busy_o !== 1'b1) begin n_bad++; $display("FAIL drain_hold got v%b busy%b want 1 1", valid_o, busy_o); end
    halt = 1'b1;
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_consume got v%b want 0", valid_o); end
    step();
    req_vld = 2'b01;
    seen = 0;
    // One halt-low cycle after five quiet cycles restarts the 16-cycle count.
    for (int c = 1; c <= 40; c++) begin
      halt = (c == 6) ? 1'b0 : 1'b1;
      step();
      if (cfg_rdy) begin seen = c; break; end
    end
    n_cmp++; if (seen != 22) begin n_bad++; $display("FAIL quiet_len got %0d want 22", seen); end
    n_cmp++; if (valid_o !== 1'b0 || req_rdy !== 2'b00) begin n_bad++; $display("FAIL quiet_noload got v%b rdy%b want 0 00", valid_o, req_rdy); end
    n_cmp++; if (screen_o !== {DEF_SCR, DEF_SCR} || lg2_o !== 2'd1) begin n_bad++; $display("FAIL apply_early got %h/%0d want %h/1", screen_o, lg2_o, {DEF_SCR, DEF_SCR}); end
    req_vld = 2'b00;
    step();
    cfg_vld = 1'b0;
    n_cmp++; if (cfg_rdy !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL apply_pulse got rdy%b busy%b want 0 0", cfg_rdy, busy_o); end
    n_cmp++; if (screen_o !== {24'h040000, 24'h040000} || ss_o !== 4'b0010 || lg2_o !== 2'd2 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL apply_cfg got %h %b %0d e%b want 040000 0010 2 e0", screen_o, ss_o, lg2_o, err_o);
    end
  endtask

  task automatic test_cfg_err();
    bit ok;
    run_cfg(24'h010000, 4'b0110, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL err_timeout got %b want 1", ok); end
    n_cmp++; if (err_o !== 1'b1 || screen_o !== {24'h040000, 24'h040000} || ss_o !== 4'b0010 || lg2_o !== 2'd2) begin
      n_bad++; $display("FAIL illegal_cfg got e%b %h %b %0d want e1 040000 0010 2", err_o, screen_o, ss_o, lg2_o);
    end
    run_cfg(24'h020000, 4'b1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL legal_timeout got %b want 1", ok); end
    n_cmp++; if (err_o !== 1'b0 || screen_o !== {24'h020000, 24'h020000} || ss_o !== 4'b1000 || lg2_o !== 2'd0) begin
      n_bad++; $display("FAIL legal_cfg got e%b %h %b %0d want e0 020000 1000 0", err_o, screen_o, ss_o, lg2_o);
    end
  endtask

  task automatic test_reset_quiet();
    req_vld = 2'b01; req_tri[0] = tri_pat(0, 400); req_color[0] = col_pat(0, 400);
    step();
    req_vld = 2'b00;
    cfg_vld = 1'b1; cfg_screen = {24'h030000, 24'h030000}; cfg_ss = 4'b0001;
    repeat (6) step();
    req_vld = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (screen_o !== {DEF_SCR, DEF_SCR} || ss_o !== 4'b0100 || lg2_o !== 2'd1) begin n_bad++; $display("FAIL async_cfg got %h %b %0d want default", screen_o, ss_o, lg2_o); end
    n_cmp++; if (valid_o !== 1'b0 || tri_o !== '0 || src_o !== 1'b0 || req_rdy !== 2'b00) begin n_bad++; $display("FAIL async_data got v%b %h s%b rdy%b want zeros", valid_o, tri_o, src_o, req_rdy); end
    n_cmp++; if (busy_o !== 1'b0 || cfg_rdy !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL async_flags got b%b r%b e%b want 0 0 0", busy_o, cfg_rdy, err_o); end
    step();
    cfg_vld = 1'b0; req_vld = 2'b00;
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %b want 0", busy_o); end
    req_vld = 2'b01; req_tri[0] = tri_pat(0, 500); req_color[0] = col_pat(0, 500);
    #1;
    n_cmp++; if (req_rdy !== 2'b01) begin n_bad++; $display("FAIL post_rst_rdy got %b want 01", req_rdy); end
    step();
    req_vld = 2'b00;
    n_cmp++; if (valid_o !== 1'b1 || tri_o !== tri_pat(0, 500) || screen_o !== {DEF_SCR, DEF_SCR}) begin
      n_bad++; $display("FAIL post_rst_run got v%b %h scr %h", valid_o, tri_o, screen_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_halt();
    test_cfg_apply();
    test_cfg_err();
    test_reset_quiet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rast_tri_arb.md
RAST_TRI_ARB -- requirements
Module: rast_tri_arb

Interface
REQ-001 Parameters SHALL be: SIGFIG=24 (bits per coordinate/color); RADIX=10 (fraction bits); VERTS=3 (vertices per triangle); AXIS=3 (axes per vertex); COLORS=3 (color channels); DRAIN_CYC=16 (quiet cycles before a config change is applied).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_RnnnnL  in  1  asynchronous, active-low reset.
REQ-004 req_vld_R0H  in  [1:0]  per-requester triangle valid.
REQ-005 req_tri_R0S  in  [1:0][VERTS][AXIS] x SIGFIG signed  per-requester vertices.
REQ-006 req_color_R0U  in  [1:0][COLORS] x SIGFIG unsigned  per-requester color.
REQ-007 req_rdy_R0H  out  [1:0]  per-requester accept; a transfer occurs when vld and rdy are both high.
REQ-008 halt_RnnnnL  in  1  rasterizer ready; high = rasterizer accepts this cycle.
REQ-009 tri_R10S / color_R10U / validTri_R10H  out  same widths as request  triangle presented to rasterizer.
REQ-010 src_R10U  out  1  index of the requester that owns the presented triangle.
REQ-011 cfg_vld_RnnnnH in 1; cfg_screen_RnnnnS in [1:0] x SIGFIG; cfg_subSample_RnnnnU in 4; cfg_rdy_RnnnnH out 1  config request handshake.
REQ-012 screen_RnnnnS out [1:0] x SIGFIG; subSample_RnnnnU out 4; ss_w_lg2_RnnnnS out 2  active rasterizer configuration.
REQ-013 cfg_err_RnnnnH out 1 (sticky illegal-config flag); busy_RnnnnH out 1 (high whenever state != RUN or validTri_R10H = 1).

Function
REQ-014 Output stage SHALL be one register; a triangle is consumed when validTri_R10H=1 and halt_RnnnnL=1; while halt_RnnnnL=0, all outputs SHALL hold.
REQ-015 load_ok = (state==RUN) & (!validTri_R10H | halt_RnnnnL).
REQ-016 req_rdy_R0H[i] = load_ok & grant[i], where grant is a pure function of req_vld_R0H and the round-robin pointer. req_vld_R0H SHALL NOT depend on req_rdy_R0H.
REQ-017 Round robin: when only one requester is valid, it is granted; when both are valid, the requester not equal to the pointer is granted; the pointer SHALL update to the granted index on every transfer only.
REQ-018 Latency: a triangle accepted at edge N SHALL appear on validTri_R10H/tri/color/src after edge N, i.e. one cycle, with fields bit-exact.
REQ-019 Consume and load in the same cycle SHALL give back-to-back valid output, with no bubble.
REQ-020 Consume without load SHALL clear validTri_R10H on the next cycle; data fields SHALL hold their last value.
REQ-021 FSM states: RUN, DRAIN, QUIET, APPLY.
REQ-022 RUN -> DRAIN when cfg_vld_RnnnnH=1. A request accepted in that same cycle SHALL still complete.
REQ-023 DRAIN: no new loads. DRAIN -> QUIET when validTri_R10H=0.
REQ-024 QUIET: a 5-bit counter counts cycles with halt_RnnnnL=1; it SHALL clear to 0 on any cycle with halt_RnnnnL=0; QUIET -> APPLY when the counter reaches DRAIN_CYC-1.
REQ-025 APPLY lasts one cycle and asserts cfg_rdy_RnnnnH=1, then the FSM returns to RUN. cfg_vld_RnnnnH SHALL be held until that cycle; the data is sampled in APPLY.
REQ-026 Legal cfg_subSample values are one-hot: 1000->ss_w_lg2 0, 0100->1, 0010->2, 0001->3. A legal value SHALL update screen/subSample/ss_w_lg2 and clear cfg_err_RnnnnH.
REQ-027 An illegal (non-one-hot) value SHALL keep the old configuration and set cfg_err_RnnnnH, which stays set until the next legal apply.
REQ-028 Configuration outputs SHALL change only on the APPLY edge.

Reset
REQ-029 While rst_RnnnnL=0, outputs SHALL be: validTri_R10H=0; tri_R10S, color_R10U, src_R10U = 0; screen_RnnnnS[0] and [1] = 0x080000 (512.0); subSample_RnnnnU=0100; ss_w_lg2_RnnnnS=1; cfg_err_RnnnnH=0; cfg_rdy_RnnnnH=0; req_rdy_R0H=0.
REQ-030 Reset SHALL also set state=RUN, pointer=1 (requester 0 wins first tie), and counter=0.
REQ-031 Reset asserted mid-operation SHALL drop any in-flight triangle and abort a pending config, with no partial apply.

Structure
REQ-032 A shared package SHALL hold: the FSM state enum, the default screen/subSample constants, and the subSample->ss_w_lg2 decode function.
REQ-033 One sub-module, rast_rr_arb2, SHALL provide the 2-way round-robin grant and pointer.

Verification
REQ-034 Reset release with halt_RnnnnL=1 and only req 0 presenting tri A at cycle 5 -> validTri_R10H=1 with A and src=0 at cycle 6; req_rdy=01 at cycle 5.
REQ-035 Both requesters continuously valid with halt_RnnnnL=1 -> src sequence 0,1,0,1...; one triangle per cycle; no duplicates or drops across 100 triangles.
REQ-036 halt_RnnnnL=0 for 7 cycles while a triangle is held -> outputs stable, req_rdy=00; halt high -> the next triangle appears one cycle later.
REQ-037 cfg_vld with screen 0x040000/0x040000 and subSample 0010 while a triangle is pending -> it drains; QUIET lasts 16 cycles; one more halt low mid-QUIET restarts the count; APPLY gives screen=256, ss_w_lg2=2, cfg_rdy for 1 cycle.
REQ-038 cfg_subSample=0110 -> config unchanged, cfg_err=1; a following legal 1000 -> ss_w_lg2=0 and cfg_err=0.
REQ-039 rst_RnnnnL low during QUIET -> all REQ-029 values appear immediately (asynchronously); after release the FSM is in RUN.
